// File: rtl/ldst_io_bridge.sv
// Load/store bridge: routes CPU accesses to data memory or local I/O
// (switches, LEDs, interval timer) with a uniform one-cycle read latency.
module ldst_io_bridge #(
  parameter int unsigned    IW       = 32,
  parameter logic [IW-1:0]  MEM_TOP  = 32'h8000,
  parameter logic [IW-1:0]  SW_ADDR  = 32'hA000,
  parameter logic [IW-1:0]  LED_ADDR = 32'hA010,
  parameter logic [IW-1:0]  TMR_BASE = 32'hA020
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] i_ldst_addr,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [IW-1:0] i_ldst_wrdata,
  input  logic [3:0]    i_ldst_byte_en,
  output logic [IW-1:0] o_ldst_rddata,
  output logic [IW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [IW-1:0] o_mem_wrdata,
  output logic [3:0]    o_mem_byte_en,
  input  logic [IW-1:0] i_mem_rddata,
  input  logic [7:0]    i_sw,
  output logic [7:0]    o_ledr
);

  localparam logic [IW-1:0] CNT_ADDR = TMR_BASE;
  localparam logic [IW-1:0] CTL_ADDR = TMR_BASE + IW'(4);
  localparam logic [IW-1:0] PER_ADDR = TMR_BASE + IW'(8);

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_IO   = 2'd2
  } rd_sel_e;

  logic [IW-3:0] wa;
  logic          hit_mem;
  logic          hit_sw;
  logic          hit_led;
  logic          hit_cnt;
  logic          hit_ctl;
  logic          hit_per;
  logic          hit_io;
  logic          rd_ok;
  logic          wr_ok;

  logic [7:0]    sw_s1_q;
  logic [7:0]    sw_s2_q;
  logic [7:0]    led_q;
  logic [7:0]    led_d;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;
  logic [IW-1:0] per_q;
  logic [IW-1:0] per_d;
  logic          en_q;
  logic          en_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          wrap;

  rd_sel_e       rd_sel_q;
  rd_sel_e       rd_sel_d;
  logic [IW-1:0] io_q;
  logic [IW-1:0] io_d;
  logic [IW-1:0] io_val;

  function automatic logic [IW-1:0] bmerge(
    input logic [IW-1:0] old_v,
    input logic [IW-1:0] new_v,
    input logic [3:0]    be
  );
    logic [IW-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Address decode
  assign wa      = i_ldst_addr[IW-1:2];
  assign hit_mem = i_ldst_addr < MEM_TOP;
  assign hit_sw  = wa == SW_ADDR[IW-1:2];
  assign hit_led = wa == LED_ADDR[IW-1:2];
  assign hit_cnt = wa == CNT_ADDR[IW-1:2];
  assign hit_ctl = wa == CTL_ADDR[IW-1:2];
  assign hit_per = wa == PER_ADDR[IW-1:2];
  assign hit_io  = hit_sw | hit_led | hit_cnt
                 | hit_ctl | hit_per;

  // Strobes are dead while reset is held
  assign rd_ok = i_ldst_rd & ~reset;
  assign wr_ok = i_ldst_wr & ~reset;

  assign o_mem_addr    = i_ldst_addr;
  assign o_mem_wrdata  = i_ldst_wrdata;
  assign o_mem_byte_en = i_ldst_byte_en;
  assign o_mem_rd      = rd_ok & hit_mem;
  assign o_mem_wr      = wr_ok & hit_mem;
  assign o_ledr        = led_q;

  always_comb begin
    led_d = led_q;
    if (wr_ok && hit_led && i_ldst_byte_en[0]) begin
      led_d = i_ldst_wrdata[7:0];
    end
  end

  // Timer: a CPU write overrides the count step, a wrap overrides OVF clear
  always_comb begin
    wrap  = en_q & (cnt_q == per_q);
    cnt_d = cnt_q;
    per_d = per_q;
    en_d  = en_q;
    ovf_d = ovf_q;
    if (en_q) begin
      cnt_d = wrap ? '0 : cnt_q + IW'(1);
    end
    if (wr_ok && hit_cnt) begin
      cnt_d = bmerge(cnt_q, i_ldst_wrdata, i_ldst_byte_en);
    end
    if (wr_ok && hit_per) begin
      per_d = bmerge(per_q, i_ldst_wrdata, i_ldst_byte_en);
    end
    if (wr_ok && hit_ctl) begin
      en_d = i_ldst_wrdata[0];
      if (i_ldst_wrdata[1]) ovf_d = 1'b0;
    end
    if (wrap) ovf_d = 1'b1;
  end

  always_comb begin
    io_val = '0;
    unique case (1'b1)
      hit_sw:  io_val = {{(IW-8){1'b0}}, sw_s2_q};
      hit_led: io_val = {{(IW-8){1'b0}}, led_q};
      hit_cnt: io_val = cnt_q;
      hit_ctl: io_val = {{(IW-2){1'b0}}, ovf_q, en_q};
      hit_per: io_val = per_q;
      default: io_val = '0;
    endcase
  end

  always_comb begin
    rd_sel_d = rd_sel_q;
    io_d     = io_q;
    if (rd_ok) begin
      if (hit_mem) begin
        rd_sel_d = SEL_MEM;
      end else if (hit_io) begin
        rd_sel_d = SEL_IO;
        io_d     = io_val;
      end else begin
        rd_sel_d = SEL_ZERO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rd_sel_q <= SEL_ZERO;
      io_q     <= '0;
    end else begin
      sw_s1_q  <= i_sw;
      sw_s2_q  <= sw_s1_q;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      rd_sel_q <= rd_sel_d;
      io_q     <= io_d;
    end
  end

  always_comb begin
    o_ldst_rddata = '0;
    unique case (rd_sel_q)
      SEL_MEM:  o_ldst_rddata = i_mem_rddata;
      SEL_IO:   o_ldst_rddata = io_q;
      default:  o_ldst_rddata = '0;
    endcase
  end

endmodule

// File: tb/tb_ldst_io_bridge.sv
// Bench for ldst_io_bridge: directed cases then random traffic
// against a transaction-level model of the memory map.
module tb_ldst_io_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_ldst_addr = '0;
  logic        i_ldst_rd = 1'b0;
  logic        i_ldst_wr = 1'b0;
  logic [31:0] i_ldst_wrdata = '0;
  logic [3:0]  i_ldst_byte_en = '0;
  logic [31:0] o_ldst_rddata;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [31:0] o_mem_wrdata;
  logic [3:0]  o_mem_byte_en;
  logic [31:0] i_mem_rddata = '0;
  logic [7:0]  i_sw = '0;
  logic [7:0]  o_ledr;

  int n_chk = 0;
  int n_fail = 0;

  ldst_io_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .i_ldst_addr    (i_ldst_addr),
    .i_ldst_rd      (i_ldst_rd),
    .i_ldst_wr      (i_ldst_wr),
    .i_ldst_wrdata  (i_ldst_wrdata),
    .i_ldst_byte_en (i_ldst_byte_en),
    .o_ldst_rddata  (o_ldst_rddata),
    .o_mem_addr     (o_mem_addr),
    .o_mem_rd       (o_mem_rd),
    .o_mem_wr       (o_mem_wr),
    .o_mem_wrdata   (o_mem_wrdata),
    .o_mem_byte_en  (o_mem_byte_en),
    .i_mem_rddata   (i_mem_rddata),
    .i_sw           (i_sw),
    .o_ledr         (o_ledr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bmerge(
    input logic [31:0] o, input logic [31:0] n,
    input logic [3:0] be
  );
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Synchronous data memory seen by the bridge
  logic [31:0] env_mem [0:8191];
  always @(posedge clk) begin
    if (o_mem_rd) i_mem_rddata <= env_mem[o_mem_addr[14:2]];
    if (o_mem_wr)
      env_mem[o_mem_addr[14:2]] <=
        bmerge(env_mem[o_mem_addr[14:2]], o_mem_wrdata, o_mem_byte_en);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  localparam int R_MEM = 0, R_SW = 1, R_LED = 2, R_CNT = 3;
  localparam int R_CTL = 4, R_PER = 5, R_NONE = 6;
  logic [31:0] ref_mem [0:8191];
  logic [7:0]  m_led;
  logic [31:0] m_cnt, m_per, m_rdata;
  logic        m_en, m_ovf;
  logic [7:0]  sw_hist [2];

  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (a < 32'h8000) return R_MEM;
    if (w == 32'hA000) return R_SW;
    if (w == 32'hA010) return R_LED;
    if (w == 32'hA020) return R_CNT;
    if (w == 32'hA024) return R_CTL;
    if (w == 32'hA028) return R_PER;
    return R_NONE;
  endfunction

  task automatic model_step(input logic rst, rd, wr,
                            input logic [31:0] a, d,
                            input logic [3:0] be,
                            input logic [7:0] sw);
    int r;
    logic wrap;
    logic [31:0] ncnt;
    if (rst) begin
      m_led = 0; m_cnt = 0; m_per = 0; m_en = 0; m_ovf = 0;
      m_rdata = 0; sw_hist[0] = 0; sw_hist[1] = 0;
      return;
    end
    r = region(a);
    if (rd) begin
      case (r)
        R_MEM:   m_rdata = ref_mem[a[14:2]];
        R_SW:    m_rdata = {24'b0, sw_hist[1]};
        R_LED:   m_rdata = {24'b0, m_led};
        R_CNT:   m_rdata = m_cnt;
        R_CTL:   m_rdata = {30'b0, m_ovf, m_en};
        R_PER:   m_rdata = m_per;
        default: m_rdata = 0;
      endcase
    end
    wrap = m_en && (m_cnt == m_per);
    ncnt = wrap ? 32'd0 : (m_en ? m_cnt + 1 : m_cnt);
    if (wr) begin
      case (r)
        R_MEM: ref_mem[a[14:2]] = bmerge(ref_mem[a[14:2]], d, be);
        R_LED: if (be[0]) m_led = d[7:0];
        R_CNT: ncnt = bmerge(m_cnt, d, be);
        R_PER: m_per = bmerge(m_per, d, be);
        R_CTL: begin
          m_en = d[0];
          if (d[1]) m_ovf = 0;
        end
        default: ;
      endcase
    end
    if (wrap) m_ovf = 1;
    m_cnt = ncnt;
    sw_hist[1] = sw_hist[0];
    sw_hist[0] = sw;
  endtask

  // One bus cycle: drive, check strobes, clock, check outputs
  task automatic cyc(input logic rst, rd, wr,
                     input logic [31:0] a, d,
                     input logic [3:0] be,
                     input logic [7:0] sw);
    logic mem;
    reset = rst; i_ldst_rd = rd; i_ldst_wr = wr;
    i_ldst_addr = a; i_ldst_wrdata = d;
    i_ldst_byte_en = be; i_sw = sw;
    mem = (a < 32'h8000);
    #1;
    chk("mem_rd", 32'(o_mem_rd), 32'(rd & mem & ~rst));
    chk("mem_wr", 32'(o_mem_wr), 32'(wr & mem & ~rst));
    chk("mem_addr", o_mem_addr, a);
    @(posedge clk);
    model_step(rst, rd, wr, a, d, be, sw);
    #1;
    chk("rddata", o_ldst_rddata, m_rdata);
    chk("ledr", 32'(o_ledr), 32'(m_led));
  endtask

  task automatic rd_(input logic [31:0] a, input logic [7:0] sw);
    cyc(0, 1, 0, a, 0, 4'h0, sw);
  endtask

  task automatic wr_(input logic [31:0] a, d,
                     input logic [3:0] be, input logic [7:0] sw);
    cyc(0, 0, 1, a, d, be, sw);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return 32'($urandom_range(0, 63)) << 2;
      3: return 32'hA000;
      4: return 32'hA010;
      5: return 32'hA020;
      6: return 32'hA024;
      7: return 32'hA028;
      8: return 32'h7FFC;
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h8000;
          1: return 32'h9000;
          2: return 32'hA030;
          3: return 32'hA004;
          default: return 32'hFFFF_FFFC;
        endcase
      end
    endcase
  endfunction

  logic [31:0] seq [5];
  logic [7:0]  rsw;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      env_mem[i] = 0;
      ref_mem[i] = 0;
    end
    sw_hist[0] = 0; sw_hist[1] = 0;
    m_led = 0; m_cnt = 0; m_per = 0; m_en = 0; m_ovf = 0; m_rdata = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h100, 32'h1234, 4'hF, 0);
    chk("reset_rd", o_ldst_rddata, 0);
    chk("reset_led", 32'(o_ledr), 0);

    rd_(32'hA010, 0);
    chk("led_rd0", o_ldst_rddata, 0);
    wr_(32'hA010, 32'h1A5, 4'h1, 0);
    chk("led_a5", 32'(o_ledr), 32'hA5);
    wr_(32'hA010, 32'hFF, 4'hE, 0);
    chk("led_be", 32'(o_ledr), 32'hA5);
    rd_(32'hA010, 0);
    chk("led_rd", o_ldst_rddata, 32'hA5);

    cyc(0, 0, 0, 0, 0, 0, 8'h3C);
    cyc(0, 0, 0, 0, 0, 0, 8'h3C);
    rd_(32'hA000, 8'h3C);
    chk("sw_3c", o_ldst_rddata, 32'h3C);
    cyc(0, 0, 0, 0, 0, 0, 8'h55);
    rd_(32'hA000, 8'h55);
    chk("sw_old", o_ldst_rddata, 32'h3C);
    rd_(32'hA000, 8'h55);
    chk("sw_new", o_ldst_rddata, 32'h55);

    wr_(32'h100, 32'hDEADBEEF, 4'hF, 8'h55);
    rd_(32'h100, 8'h55);
    chk("mem_rd_data", o_ldst_rddata, 32'hDEADBEEF);
    rd_(32'h9000, 8'h55);
    chk("unmapped_rd", o_ldst_rddata, 0);
    wr_(32'h9000, 32'h5, 4'hF, 8'h55);

    wr_(32'hA028, 3, 4'hF, 8'h55);
    wr_(32'hA024, 1, 4'hF, 8'h55);
    for (int i = 0; i < 5; i++) begin
      rd_(32'hA020, 8'h55);
      seq[i] = o_ldst_rddata;
    end
    chk("cnt_seq0", seq[0], 0);
    chk("cnt_seq1", seq[1], 1);
    chk("cnt_seq2", seq[2], 2);
    chk("cnt_seq3", seq[3], 3);
    chk("cnt_seq4", seq[4], 0);
    rd_(32'hA024, 8'h55);
    chk("ovf_set", o_ldst_rddata, 3);
    cyc(0, 0, 0, 0, 0, 0, 8'h55);
    wr_(32'hA024, 3, 4'hF, 8'h55);
    rd_(32'hA024, 8'h55);
    chk("ovf_wrap_wins", o_ldst_rddata, 3);
    wr_(32'hA024, 3, 4'hF, 8'h55);
    rd_(32'hA024, 8'h55);
    chk("ovf_clear", o_ldst_rddata, 1);
    cyc(0, 1, 1, 32'hA020, 32'h10, 4'hF, 8'h55);
    chk("cnt_old", o_ldst_rddata, 3);
    rd_(32'hA020, 8'h55);
    chk("cnt_new", o_ldst_rddata, 32'h10);

    cyc(1, 1, 0, 32'hA020, 0, 0, 8'h55);
    chk("rst_mid", o_ldst_rddata, 0);
    rd_(32'hA020, 8'h55);
    chk("rst_cnt", o_ldst_rddata, 0);
    rd_(32'hA010, 8'h55);
    chk("rst_led", o_ldst_rddata, 0);

    rsw = 8'h55;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a, d;
      int rg;
      a = pick_addr();
      rg = region(a);
      d = (rg == R_CNT || rg == R_PER) ? 32'($urandom_range(0, 9))
                                       : $urandom;
      if ($urandom_range(0, 7) == 0) rsw = 8'($urandom);
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
          a, d, 4'($urandom), rsw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
